// File: rtl/zero_pad_stream.sv
// zero_pad_stream: streaming border-padding stage for CBS chains.
// Takes a C x H x W feature map as a valid/ready element stream (channel
// outermost, column fastest) and emits the same map wrapped in a P-element
// border of PAD_VALUE on every side of every channel. The output side is a
// single registered slot, so no combinational path runs from in_* to out_*.
// Border beats are generated internally and never consume input.
module zero_pad_stream #(
  parameter int unsigned           DATA_WIDTH = 16,
  parameter int unsigned           C          = 2,
  parameter int unsigned           H          = 2,
  parameter int unsigned           W          = 2,
  parameter int unsigned           P          = 1,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  frame_done,
  output logic                  err
);

  // Padded map geometry.
  localparam int unsigned ROWS = H + 2 * P;
  localparam int unsigned COLS = W + 2 * P;

  // Counter widths are sized to hold one past the largest compared value,
  // so H+P and W+P are representable even when P is 0.
  localparam int unsigned CH_BITS  = (C > 1) ? $clog2(C) : 1;
  localparam int unsigned ROW_BITS = $clog2(ROWS + 1);
  localparam int unsigned COL_BITS = $clog2(COLS + 1);

  localparam logic [CH_BITS-1:0]  CH_LAST      = CH_BITS'(C - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST     = ROW_BITS'(ROWS - 1);
  localparam logic [COL_BITS-1:0] COL_LAST     = COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS-1:0] ROW_INT_LAST = ROW_BITS'(H + P - 1);
  localparam logic [COL_BITS-1:0] COL_INT_LAST = COL_BITS'(W + P - 1);

  // Position of the next beat to be loaded into the output slot.
  logic [CH_BITS-1:0]  ch,  ch_nxt;
  logic [ROW_BITS-1:0] r,   r_nxt;
  logic [COL_BITS-1:0] col, col_nxt;

  logic border;            // next beat lies in the pad ring
  logic slot_free;         // output slot can take a new beat this cycle
  logic load;              // output slot is written this cycle
  logic accept;            // an input element is consumed this cycle
  logic at_frame_end;      // next beat is the final padded beat of the frame
  logic at_last_interior;  // next beat is the final interior element

  // Border classification; with no pad ring every position is interior.
  if (P == 0) begin : g_no_pad
    assign border = 1'b0;
  end else begin : g_pad
    localparam logic [ROW_BITS-1:0] ROW_TOP   = ROW_BITS'(P);
    localparam logic [ROW_BITS-1:0] ROW_BOT   = ROW_BITS'(H + P);
    localparam logic [COL_BITS-1:0] COL_LEFT  = COL_BITS'(P);
    localparam logic [COL_BITS-1:0] COL_RIGHT = COL_BITS'(W + P);

    assign border = (r < ROW_TOP) || (r >= ROW_BOT) ||
                    (col < COL_LEFT) || (col >= COL_RIGHT);
  end

  // Handshake: the slot frees when empty or when its beat is being taken,
  // which lets a held beat drain and the next one load on the same edge.
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = slot_free && !border;
  assign accept    = in_valid && in_ready;
  assign load      = slot_free && (border || in_valid);

  assign at_frame_end     = (ch == CH_LAST) && (r == ROW_LAST) && (col == COL_LAST);
  assign at_last_interior = (ch == CH_LAST) && (r == ROW_INT_LAST) &&
                            (col == COL_INT_LAST);

  // Position advance: column fastest, then row, then channel; the channel
  // wrap rolls straight into the next frame without an idle cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    col_nxt = col + COL_BITS'(1);
    r_nxt   = r;
    ch_nxt  = ch;
    if (col == COL_LAST) begin
      col_nxt = '0;
      r_nxt   = r + ROW_BITS'(1);
      if (r == ROW_LAST) begin
        r_nxt  = '0;
        ch_nxt = (ch == CH_LAST) ? '0 : ch + CH_BITS'(1);
      end
    end
  end

  // Position counters step once per beat loaded into the output slot.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement or block order.
    if (reset) begin
      ch  <= '0;
      r   <= '0;
      col <= '0;
    end else if (load) begin
      ch  <= ch_nxt;
      r   <= r_nxt;
      col <= col_nxt;
    end
  end

  // Output slot: load a pad or input beat, drain when taken, hold when stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= border ? PAD_VALUE : in_data;
      out_last  <= at_frame_end;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Frame status: done pulse after the final beat is taken; sticky framing
  // error when in_last disagrees with the expected last interior element.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      frame_done <= out_valid && out_ready && out_last;
      if (accept && (in_last != at_last_interior)) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_zero_pad_stream.sv
// Self-checking bench for zero_pad_stream. Three instances cover the padded
// 2x2x2 map (P=1), the pass-through case (P=0) and a wide ring (P=2).
// Stimulus pushes expected beats into a scoreboard queue; a negedge monitor
// pops and compares whenever an instance presents an accepted beat.
module tb_zero_pad_stream;

  localparam int N = 3;  // 0: C2 H2 W2 P1, 1: C1 H2 W2 P0, 2: C1 H2 W2 P2

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic [N-1:0][15:0]   in_data;
  logic [N-1:0]         in_valid;
  logic [N-1:0]         in_last;
  logic [N-1:0]         in_ready;
  logic [N-1:0][15:0]   out_data;
  logic [N-1:0]         out_valid;
  logic [N-1:0]         out_last;
  logic [N-1:0]         out_ready;
  logic [N-1:0]         frame_done;
  logic [N-1:0]         err;

  zero_pad_stream #(.DATA_WIDTH(16), .C(2), .H(2), .W(2), .P(1), .PAD_VALUE(16'h0000)) dut_a (
    .clk(clk), .reset(reset),
    .in_data(in_data[0]), .in_valid(in_valid[0]), .in_last(in_last[0]), .in_ready(in_ready[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_last(out_last[0]), .out_ready(out_ready[0]),
    .frame_done(frame_done[0]), .err(err[0])
  );

  zero_pad_stream #(.DATA_WIDTH(16), .C(1), .H(2), .W(2), .P(0), .PAD_VALUE(16'hFC00)) dut_b (
    .clk(clk), .reset(reset),
    .in_data(in_data[1]), .in_valid(in_valid[1]), .in_last(in_last[1]), .in_ready(in_ready[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_last(out_last[1]), .out_ready(out_ready[1]),
    .frame_done(frame_done[1]), .err(err[1])
  );

  zero_pad_stream #(.DATA_WIDTH(16), .C(1), .H(2), .W(2), .P(2), .PAD_VALUE(16'hFC00)) dut_c (
    .clk(clk), .reset(reset),
    .in_data(in_data[2]), .in_valid(in_valid[2]), .in_last(in_last[2]), .in_ready(in_ready[2]),
    .out_data(out_data[2]), .out_valid(out_valid[2]), .out_last(out_last[2]), .out_ready(out_ready[2]),
    .frame_done(frame_done[2]), .err(err[2])
  );

  typedef struct {
    int          dut;
    logic [15:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  int              popped   [N];
  int              last_cnt [N];
  logic [N-1:0]    fd_pend;
  logic [N-1:0]    stalled;
  logic [N-1:0][15:0] held_data;
  logic [N-1:0]    held_last;
  beat_t           mon_e;

  initial begin
    for (int k = 0; k < N; k++) begin
      popped[k]   = 0;
      last_cnt[k] = 0;
    end
    fd_pend = '0;
    stalled = '0;
  end

  always @(negedge clk) begin
    if (reset) begin
      fd_pend = '0;
      stalled = '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        check($sformatf("frame_done[%0d]", k), 32'(frame_done[k]), 32'(fd_pend[k]));
        fd_pend[k] = 1'b0;
        if (stalled[k]) begin
          check($sformatf("hold_valid[%0d]", k), 32'(out_valid[k]), 32'd1);
          check($sformatf("hold_data[%0d]", k), 32'(out_data[k]), 32'(held_data[k]));
          check($sformatf("hold_last[%0d]", k), 32'(out_last[k]), 32'(held_last[k]));
        end
        stalled[k]   = out_valid[k] && !out_ready[k];
        held_data[k] = out_data[k];
        held_last[k] = out_last[k];
        if (stalled[k]) check($sformatf("stall_in_ready[%0d]", k), 32'(in_ready[k]), 32'd0);
        if (out_valid[k] && out_ready[k]) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_beat[%0d]: got data %0h, expected no beat", k, out_data[k]);
          end else begin
            mon_e = exp_q.pop_front();
            check($sformatf("beat_source[%0d]", k), 32'(k), 32'(mon_e.dut));
            check($sformatf("out_data[%0d] beat %0d", k, popped[k]), 32'(out_data[k]), 32'(mon_e.data));
            check($sformatf("out_last[%0d] beat %0d", k, popped[k]), 32'(out_last[k]), 32'(mon_e.last));
            popped[k]++;
            if (mon_e.last) begin
              last_cnt[k]++;
              fd_pend[k] = 1'b1;
            end
          end
        end
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  int act      = 0;
  bit rdy_on   = 1'b0;
  bit rdy_rand = 1'b0;

  // Hand-computed padded frame for inputs 1..8 with C=2, H=2, W=2, P=1.
  logic [15:0] exp_a [32] = '{
    16'd0, 16'd0, 16'd0, 16'd0,
    16'd0, 16'd1, 16'd2, 16'd0,
    16'd0, 16'd3, 16'd4, 16'd0,
    16'd0, 16'd0, 16'd0, 16'd0,
    16'd0, 16'd0, 16'd0, 16'd0,
    16'd0, 16'd5, 16'd6, 16'd0,
    16'd0, 16'd7, 16'd8, 16'd0,
    16'd0, 16'd0, 16'd0, 16'd0
  };
  logic [15:0] v18 [8] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
  logic [15:0] vb  [8] = '{16'h3C00, 16'h4000, 16'hBC00, 16'h7BFF, 16'd0, 16'd0, 16'd0, 16'd0};
  logic [15:0] v14 [8] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0};

  // One clock step; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (rdy_on) out_ready[act] = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
  endtask

  task automatic push_a();
    for (int i = 0; i < 32; i++) exp_q.push_back('{0, exp_a[i], i == 31});
  endtask

  task automatic push_b();
    for (int i = 0; i < 4; i++) exp_q.push_back('{1, vb[i], i == 3});
  endtask

  // 6x6 map: interior rows/cols 2..3 carry inputs 1..4, the rest is -inf.
  task automatic push_c();
    logic [15:0] d;
    for (int rr = 0; rr < 6; rr++) begin
      for (int cc = 0; cc < 6; cc++) begin
        if (rr >= 2 && rr < 4 && cc >= 2 && cc < 4) d = 16'(1 + (rr - 2) * 2 + (cc - 2));
        else d = 16'hFC00;
        exp_q.push_back('{2, d, (rr == 5) && (cc == 5)});
      end
    end
  endtask

  // Offer n elements to instance k, each after 'gap' idle cycles.
  task automatic feed(input int k, input logic [15:0] vals [8], input int n, input int gap,
                      input logic [7:0] last_mask, input int err_at);
    bit acc;
    for (int i = 0; i < n; i++) begin
      repeat (gap) step();
      in_data[k]  = vals[i];
      in_valid[k] = 1'b1;
      in_last[k]  = last_mask[i];
      acc = 1'b0;
      for (int t = 0; t < 200 && !acc; t++) begin
        @(negedge clk);
        acc = in_ready[k];
        step();
      end
      in_valid[k] = 1'b0;
      in_last[k]  = 1'b0;
      if (!acc) begin
        n_checks++;
        n_errors++;
        $display("FAIL input_accept_timeout[%0d]: element %0d never accepted, expected acceptance", k, i);
        return;
      end
      check($sformatf("latency_valid[%0d] elem %0d", k, i), 32'(out_valid[k]), 32'd1);
      check($sformatf("latency_data[%0d] elem %0d", k, i), 32'(out_data[k]), 32'(vals[i]));
      if (err_at >= 0 && i >= err_at) check($sformatf("err_set elem %0d", i), 32'(err[k]), 32'd1);
    end
  endtask

  // Run one full frame on instance k and stop the consumer right after the
  // final beat is taken, so the next frame's leading pad beat is held.
  task automatic run_frame(input int k, input logic [15:0] vals [8], input int n, input int gap,
                           input bit rnd, input logic [7:0] last_mask, input int err_at);
    int start;
    int t;
    act      = k;
    rdy_rand = rnd;
    rdy_on   = 1'b1;
    out_ready[k] = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
    start = last_cnt[k];
    feed(k, vals, n, gap, last_mask, err_at);
    t = 0;
    while (last_cnt[k] == start && t < 1000) begin
      step();
      t++;
    end
    rdy_on       = 1'b0;
    out_ready[k] = 1'b0;
    if (last_cnt[k] == start) begin
      n_checks++;
      n_errors++;
      $display("FAIL frame_end_timeout[%0d]: last beat not seen, expected within 1000 cycles", k);
    end
    check($sformatf("queue_empty_after_frame[%0d]", k), 32'(exp_q.size()), 32'd0);
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    in_valid  = '0;
    in_last   = '0;
    out_ready = '0;
    rdy_on    = 1'b0;
    exp_q.delete();
    step();
    for (int k = 0; k < N; k++) begin
      check($sformatf("reset_out_valid[%0d]", k), 32'(out_valid[k]), 32'd0);
      check($sformatf("reset_out_data[%0d]", k), 32'(out_data[k]), 32'd0);
      check($sformatf("reset_out_last[%0d]", k), 32'(out_last[k]), 32'd0);
      check($sformatf("reset_frame_done[%0d]", k), 32'(frame_done[k]), 32'd0);
      check($sformatf("reset_err[%0d]", k), 32'(err[k]), 32'd0);
    end
    step();
    reset = 1'b0;
  endtask

  initial begin
    int start;
    int t;
    reset     = 1'b1;
    in_data   = '0;
    in_valid  = '0;
    in_last   = '0;
    out_ready = '0;
    apply_reset();

    // Continuous input, consumer always ready.
    push_a();
    run_frame(0, v18, 8, 0, 1'b0, 8'h80, -1);
    check("err_after_clean_frame", 32'(err[0]), 32'd0);

    // Input valid only every third cycle; pad beats flow without input.
    push_a();
    run_frame(0, v18, 8, 2, 1'b0, 8'h80, -1);

    // Consumer stalls pseudo-randomly.
    push_a();
    run_frame(0, v18, 8, 0, 1'b1, 8'h80, -1);

    // P=0: pass-through with one cycle of latency.
    push_b();
    run_frame(1, vb, 4, 0, 1'b0, 8'h08, -1);

    // P=2: 6x6 map with a -inf ring.
    push_c();
    run_frame(2, v14, 4, 0, 1'b0, 8'h08, -1);

    // Early in_last on element 3 of 8: sticky error, stream continues.
    check("err_before_bad_frame", 32'(err[0]), 32'd0);
    push_a();
    run_frame(0, v18, 8, 0, 1'b0, 8'h84, 2);
    repeat (3) step();
    check("err_sticky_after_frame", 32'(err[0]), 32'd1);
    apply_reset();

    // Reset after 10 output beats, then a clean frame from position zero.
    push_a();
    act      = 0;
    rdy_rand = 1'b0;
    rdy_on   = 1'b1;
    out_ready[0] = 1'b1;
    start = popped[0];
    feed(0, v18, 3, 0, 8'h00, -1);
    t = 0;
    while (popped[0] - start < 10 && t < 200) begin
      step();
      t++;
    end
    repeat (3) step();
    check("beats_before_reset", 32'(popped[0] - start), 32'd10);
    apply_reset();
    push_a();
    run_frame(0, v18, 8, 0, 1'b0, 8'h80, -1);
    check("err_after_restart", 32'(err[0]), 32'd0);

    repeat (5) step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
